spi: RTL and testbench

//  Full-duplex 8-bit SPI master, MSB first, all four CPOL/CPHA modes.
//  A local shift register is loaded from data_in, sent on mosi, and refilled from miso.
//  The byte received from the slave is presented on data_out with a one-cycle done pulse.

---
 rtl/spi.sv | 151 +++++++++++++++
 tb/tb_spi.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi.sv
// Full-duplex 8-bit SPI master, MSB first, all four CPOL/CPHA modes, no chip-select.
// One shift register carries TX bits out on mosi and collects RX bits from miso.
module spi #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       data_out_received,
  input  logic       w_CPOL,
  input  logic       w_CPHA,
  input  logic       miso,
  output logic       mosi,
  output logic       slave_clk
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_shreg, w_shreg_d;
  logic [7:0]      r_data_out, w_data_out_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic            r_mosi, w_mosi_d;
  logic            r_sclk, w_sclk_d;
  logic            r_cpol, w_cpol_d;
  logic            r_cpha, w_cpha_d;
  logic [DivW-1:0] r_div, w_div_d;
  logic [4:0]      r_edge, w_edge_d;
  logic            w_tick;
  logic            w_lead;

  assign w_tick = (r_div == DivW'(CLK_DIV - 1));
  // Edge number r_edge+1 is odd (leading) when r_edge is even.
  assign w_lead = ~r_edge[0];

  always_comb begin
    w_state_d    = r_state;
    w_shreg_d    = r_shreg;
    w_data_out_d = r_data_out;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;
    w_mosi_d     = r_mosi;
    w_sclk_d     = r_sclk;
    w_cpol_d     = r_cpol;
    w_cpha_d     = r_cpha;
    w_div_d      = r_div;
    w_edge_d     = r_edge;

    unique case (r_state)
      StIdle: begin
        w_sclk_d = w_CPOL;
        if (load) begin
          w_shreg_d = data_in;
          w_mosi_d  = data_in[7];
        end else begin
          w_mosi_d  = r_shreg[7];
        end
        if (start) begin
          w_cpol_d  = w_CPOL;
          w_cpha_d  = w_CPHA;
          w_busy_d  = 1'b1;
          w_div_d   = '0;
          w_edge_d  = '0;
          w_state_d = StXfer;
        end
      end

      StXfer: begin
        if (w_tick) begin
          w_div_d  = '0;
          w_sclk_d = ~r_sclk;
          w_edge_d = r_edge + 5'd1;
          // Sampling and shifting share one step, so the next TX bit is already at bit 7.
          if (!r_cpha) begin
            if (w_lead) begin
              w_shreg_d = {r_shreg[6:0], miso};
            end else if (r_edge != 5'd15) begin
              w_mosi_d  = r_shreg[7];
            end
          end else begin
            if (w_lead) begin
              w_mosi_d  = r_shreg[7];
            end else begin
              w_shreg_d = {r_shreg[6:0], miso};
            end
          end
          if (r_edge == 5'd15) begin
            w_state_d = StDone;
          end
        end else begin
          w_div_d = r_div + DivW'(1);
        end
      end

      StDone: begin
        w_busy_d     = 1'b0;
        w_data_out_d = r_shreg;
        w_done_d     = 1'b1;
        w_mosi_d     = r_shreg[7];
        w_sclk_d     = r_cpol;
        w_state_d    = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_shreg    <= 8'hFF;
      r_data_out <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mosi     <= 1'b1;
      r_sclk     <= w_CPOL;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_div      <= '0;
      r_edge     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_shreg    <= w_shreg_d;
      r_data_out <= w_data_out_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_mosi     <= w_mosi_d;
      r_sclk     <= w_sclk_d;
      r_cpol     <= w_cpol_d;
      r_cpha     <= w_cpha_d;
      r_div      <= w_div_d;
      r_edge     <= w_edge_d;
    end
  end

  assign data_out          = r_data_out;
  assign busy              = r_busy;
  assign data_out_received = r_done;
  assign mosi              = r_mosi;
  assign slave_clk         = r_sclk;

endmodule

// File: tb/tb_spi.sv
// Directed bench for the spi master: a behavioural slave watches slave_clk on negedges,
// shifts a byte out on miso and collects mosi at its sampling edges.
module tb_spi;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       load;
  logic [7:0] data_in;
  logic       cpol;
  logic       cpha;
  logic       miso = 1'b1;
  logic [7:0] data_out;
  logic       busy;
  logic       data_out_received;
  logic       mosi;
  logic       slave_clk;

  always #5 clk = ~clk;

  spi #(.CLK_DIV(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .data_in           (data_in),
    .load              (load),
    .data_out          (data_out),
    .busy              (busy),
    .data_out_received (data_out_received),
    .w_CPOL            (cpol),
    .w_CPHA            (cpha),
    .miso              (miso),
    .mosi              (mosi),
    .slave_clk         (slave_clk)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Slave model; re-armed whenever arm_seq changes.
  int         arm_seq  = 0;
  int         seen_seq = 0;
  logic [7:0] arm_tx   = 8'h00;
  logic       arm_cpha = 1'b0;
  logic [7:0] s_tx, s_rx;
  int         s_edges, s_samples, s_unstable, s_busy, s_done;
  logic       prev_sclk, prev_mosi, s_lead;

  always @(negedge clk) begin
    if (seen_seq != arm_seq) begin
      seen_seq   = arm_seq;
      s_tx       = arm_tx;
      s_rx       = 8'h00;
      s_edges    = 0;
      s_samples  = 0;
      s_unstable = 0;
      s_busy     = 0;
      s_done     = 0;
      miso       = arm_tx[7];
    end else begin
      if (busy) s_busy++;
      if (data_out_received) s_done++;
      if (slave_clk !== prev_sclk) begin
        s_edges++;
        s_lead = ((s_edges % 2) == 1);
        if (s_lead != arm_cpha) begin
          s_rx = {s_rx[6:0], mosi};
          s_samples++;
          if (mosi !== prev_mosi) s_unstable++;
        end
        if ((s_edges % 16) == 0) begin
          s_tx = arm_tx;
          if (!arm_cpha) miso = s_tx[7];
        end else if (!arm_cpha && !s_lead) begin
          s_tx = s_tx << 1;
          miso = s_tx[7];
        end else if (arm_cpha && s_lead) begin
          miso = s_tx[7];
          s_tx = s_tx << 1;
        end
      end
    end
    prev_sclk = slave_clk;
    prev_mosi = mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (data_out_received !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(t < 200), 32'd1);
  endtask

  task automatic arm(input logic [7:0] stx, input logic m_cpha);
    arm_tx   = stx;
    arm_cpha = m_cpha;
    arm_seq++;
    step(1);
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] exp_do, input logic [7:0] exp_rx,
                            input int edges, input int busy_cyc, input int dones);
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_do));
    check({tag, "_slave_rx"}, 32'(s_rx), 32'(exp_rx));
    check({tag, "_edges"}, 32'(s_edges), 32'(edges));
    check({tag, "_samples"}, 32'(s_samples), 32'(edges / 2));
    check({tag, "_mosi_stable"}, 32'(s_unstable), 32'd0);
    check({tag, "_busy_cycles"}, 32'(s_busy), 32'(busy_cyc));
    check({tag, "_done_pulses"}, 32'(s_done), 32'(dones));
    check({tag, "_sclk_idle"}, 32'(slave_clk), 32'(cpol));
  endtask

  // One transfer; poke pulses load/start and flips the CPHA input while busy.
  task automatic xfer(input string tag, input logic m_cpol, input logic m_cpha,
                      input logic do_load, input logic [7:0] din, input logic [7:0] stx,
                      input logic poke, input logic [7:0] exp_do, input logic [7:0] exp_rx);
    cpol    = m_cpol;
    cpha    = m_cpha;
    load    = do_load;
    data_in = din;
    step(1);
    load = 1'b0;
    step(2);
    arm(stx, m_cpha);
    start = 1'b1;
    step(1);
    start = 1'b0;
    if (poke) begin
      step(4);
      load    = 1'b1;
      start   = 1'b1;
      data_in = 8'h00;
      cpha    = ~m_cpha;
      step(1);
      load  = 1'b0;
      start = 1'b0;
      step(1);
      cpha = m_cpha;
    end
    wait_done(tag);
    step(3);
    check_xfer(tag, exp_do, exp_rx, 16, 17, 1);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    load    = 1'b0;
    data_in = 8'h00;
    cpol    = 1'b0;
    cpha    = 1'b0;
    step(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_done", 32'(data_out_received), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd1);
    check("rst_sclk", 32'(slave_clk), 32'd0);
    reset = 1'b1;
    step(1);

    // Abort mid-transfer in mode 3 with an all-zero TX byte.
    cpol    = 1'b1;
    cpha    = 1'b1;
    load    = 1'b1;
    data_in = 8'h00;
    step(1);
    load = 1'b0;
    step(2);
    arm(8'h5A, 1'b1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    reset = 1'b0;
    step(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sclk", 32'(slave_clk), 32'd1);
    check("abort_mosi", 32'(mosi), 32'd1);
    check("abort_data_out", 32'(data_out), 32'h00);
    check("abort_done", 32'(data_out_received), 32'd0);
    step(1);
    reset = 1'b1;
    step(20);
    check("abort_no_done", 32'(s_done), 32'd0);

    // Shift register is 8'hFF after reset, so no load is needed for mode 0.
    xfer("mode0", 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 8'hAA, 8'hFF);
    xfer("mode1", 1'b0, 1'b1, 1'b1, 8'hFF, 8'hAA, 1'b0, 8'hAA, 8'hFF);
    xfer("mode2", 1'b1, 1'b0, 1'b1, 8'hFF, 8'hAA, 1'b0, 8'hAA, 8'hFF);
    xfer("mode3", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hAA, 1'b0, 8'hAA, 8'hFF);
    xfer("load3c", 1'b0, 1'b0, 1'b1, 8'h3C, 8'hC5, 1'b0, 8'hC5, 8'h3C);
    xfer("resend", 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h5A, 8'hC5);
    xfer("poke", 1'b1, 1'b1, 1'b1, 8'h96, 8'h69, 1'b1, 8'h69, 8'h96);

    // Start held high across two transfers: second one retransmits the received byte.
    begin
      int t;
      cpol    = 1'b0;
      cpha    = 1'b1;
      load    = 1'b1;
      data_in = 8'h3C;
      step(1);
      load = 1'b0;
      step(2);
      arm(8'hC5, 1'b1);
      start = 1'b1;
      t = 0;
      while (!(s_done >= 1 && busy === 1'b1) && t < 200) begin
        step(1);
        t++;
      end
      check("b2b_second_start", 32'(t < 200), 32'd1);
      start = 1'b0;
      wait_done("b2b");
      step(3);
      check_xfer("b2b", 8'hC5, 8'hC5, 32, 34, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
